fetch_stage: RTL and testbench

//  IF stage plus IF/ID pipeline register, directly upstream of hazard_det.
//  - Owns the PC and issues one-outstanding requests to a variable-latency instruction memory.
//  - Loads IF/ID with {pc, instr, valid}; decodes rs1/rs2 for hazard_det.
//  - Obeys hazard_det's pc_write/ifid_write stalls and EX-stage branch flushes.

---
 rtl/fetch_stage.sv | 164 ++++++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Purpose: IF stage owning the PC, issuing single-outstanding fetches and loading the IF/ID register.
// Latency: an instruction reaches IF/ID on the clock edge after its imem_rvalid, or on the edge after a stall releases.
// Backpressure: pc_write/ifid_write stalls park returned data in a one-entry buffer; flush overrides stalls.
module fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            ifid_write,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid,
    output logic [4:0]      ifid_rs1,
    output logic [4:0]      ifid_rs2
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_n;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_n;
    logic [31:0]     hold_instr;
    logic [31:0]     hold_instr_n;
    logic [XLEN-1:0] drain_addr;
    logic [XLEN-1:0] drain_addr_n;
    logic [XLEN-1:0] ifid_pc_n;
    logic [31:0]     ifid_instr_n;
    logic            ifid_valid_n;

    logic            stall;
    logic            avail;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_aligned;

    assign stall            = ~pc_write | ~ifid_write;
    assign avail            = ((state == ST_FETCH) & imem_rvalid) | (state == ST_HOLD);
    assign pc_plus4         = pc + XLEN'(4);
    assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

    // Request is gated by rst so it drops immediately on an asynchronous reset.
    // DRAIN keeps presenting the abandoned address until its response arrives,
    // because the PC has already been retargeted.
    assign imem_req  = ~rst & (state != ST_HOLD);
    assign imem_addr = (state == ST_DRAIN) ? drain_addr : pc;

    // Register-field decode for the hazard unit.
    assign ifid_rs1 = ifid_instr[19:15];
    assign ifid_rs2 = ifid_instr[24:20];

    // Next-state, PC, buffer and IF/ID selection.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        hold_instr_n = hold_instr;
        drain_addr_n = drain_addr;
        ifid_pc_n    = ifid_pc;
        ifid_instr_n = ifid_instr;
        ifid_valid_n = ifid_valid;

        if (flush) begin
            // Flush beats any stall: bubble into IF/ID, retarget PC, drop buffer.
            ifid_pc_n    = pc;
            ifid_instr_n = NOP_INSTR;
            ifid_valid_n = 1'b0;
            pc_n         = redirect_aligned;
            unique case (state)
                ST_FETCH: begin
                    if (!imem_rvalid) begin
                        // The request is still in flight; wait for it and discard.
                        state_n      = ST_DRAIN;
                        drain_addr_n = pc;
                    end else begin
                        state_n = ST_FETCH;
                    end
                end
                ST_HOLD:  state_n = ST_FETCH;
                ST_DRAIN: state_n = ST_DRAIN;
                default:  state_n = ST_FETCH;
            endcase
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (avail && !stall) begin
                        ifid_pc_n    = pc;
                        ifid_instr_n = imem_rdata;
                        ifid_valid_n = 1'b1;
                        pc_n         = pc_plus4;
                    end else if (avail && stall) begin
                        // Data arrived while decode is blocked: park it.
                        hold_instr_n = imem_rdata;
                        state_n      = ST_HOLD;
                    end else if (!stall) begin
                        ifid_pc_n    = pc;
                        ifid_instr_n = NOP_INSTR;
                        ifid_valid_n = 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ifid_pc_n    = pc;
                        ifid_instr_n = hold_instr;
                        ifid_valid_n = 1'b1;
                        pc_n         = pc_plus4;
                        state_n      = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    if (!stall) begin
                        ifid_pc_n    = pc;
                        ifid_instr_n = NOP_INSTR;
                        ifid_valid_n = 1'b0;
                    end
                    if (imem_rvalid) begin
                        state_n = ST_FETCH;
                    end
                end
                default: begin
                    state_n = ST_FETCH;
                end
            endcase
        end
    end

    // Control state: FSM, PC, parked instruction and abandoned address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            hold_instr <= NOP_INSTR;
            drain_addr <= RESET_PC;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            hold_instr <= hold_instr_n;
            drain_addr <= drain_addr_n;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            ifid_pc    <= ifid_pc_n;
            ifid_instr <= ifid_instr_n;
            ifid_valid <= ifid_valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        ifid_write;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   passed;
    int   total;

    // Memory model: latency counted in request cycles before rvalid.
    int   lat;
    int   wait_cnt;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .ifid_pc     (ifid_pc),
        .ifid_instr  (ifid_instr),
        .ifid_valid  (ifid_valid),
        .ifid_rs1    (ifid_rs1),
        .ifid_rs2    (ifid_rs2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h28) return 32'h00A5_8533;
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rvalid = imem_req && (wait_cnt >= lat);
    assign imem_rdata  = mem_word(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst || !imem_req || imem_rvalid) wait_cnt <= 0;
        else                                 wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    // One clock; a fresh valid IF/ID load is compared against the scoreboard.
    task automatic step();
        logic quiet;
        exp_t e;
        quiet = pc_write && ifid_write && !flush;
        @(posedge clk);
        #1;
        if (quiet && ifid_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pc", ifid_pc, 32'hxxxx_xxxx);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", ifid_pc, e.pc);
                chk("sb_instr", ifid_instr, e.instr);
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   32'(imem_req), 32'd0);
        chk({tag, "_valid"}, 32'(ifid_valid), 32'd0);
        chk({tag, "_instr"}, ifid_instr, NOP);
        chk({tag, "_pc"},    ifid_pc, 32'd0);
        chk({tag, "_addr"},  imem_addr, 32'd0);
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        lat         = 0;
        rst         = 1'b1;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        flush       = 1'b0;
        redirect_pc = '0;

        // Reset values.
        #3;
        chk_reset_vals("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'd0);

        // Zero-wait memory, no stalls: one instruction per cycle.
        for (int i = 0; i < 8; i++) begin
            push(32'(i * 4));
            step();
            chk("zw_valid", 32'(ifid_valid), 32'd1);
        end

        // Three-cycle memory: two bubbles precede each instruction.
        lat = 2;
        for (int i = 0; i < 2; i++) begin
            push(32'h20 + 32'(i * 4));
            for (int b = 0; b < 2; b++) begin
                step();
                chk("lat_bubble_valid", 32'(ifid_valid), 32'd0);
                chk("lat_bubble_instr", ifid_instr, NOP);
                chk("lat_addr_stable", imem_addr, 32'h20 + 32'(i * 4));
            end
            step();
        end

        // Response lands while IF/ID is stalled; it is parked in HOLD.
        ifid_write = 1'b0;
        step();
        step();
        step();
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_ifid_pc", ifid_pc, 32'h24);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("hold_req_kept", 32'(imem_req), 32'd0);
            chk("hold_ifid_kept", ifid_pc, 32'h24);
        end
        ifid_write = 1'b1;
        push(32'h28);
        step();
        chk("hold_instr", ifid_instr, 32'h00A5_8533);
        chk("hold_rs1", 32'(ifid_rs1), 32'd11);
        chk("hold_rs2", 32'(ifid_rs2), 32'd10);

        // Flush while a request is outstanding: late data discarded.
        step();
        flush       = 1'b1;
        redirect_pc = 32'h100;
        step();
        flush = 1'b0;
        chk("drain_req", 32'(imem_req), 32'd1);
        chk("drain_addr_old", imem_addr, 32'h2C);
        chk("drain_valid", 32'(ifid_valid), 32'd0);
        step();
        chk("drain_discard_valid", 32'(ifid_valid), 32'd0);
        chk("drain_new_addr", imem_addr, 32'h100);
        push(32'h100);
        step();
        chk("redir_addr_stable1", imem_addr, 32'h100);
        step();
        chk("redir_addr_stable2", imem_addr, 32'h100);
        step();

        // Flush together with a stall: flush wins, low PC bits dropped.
        lat         = 0;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        flush       = 1'b1;
        redirect_pc = 32'h103;
        step();
        flush = 1'b0;
        chk("fs_valid", 32'(ifid_valid), 32'd0);
        chk("fs_instr", ifid_instr, NOP);
        chk("fs_addr", imem_addr, 32'h100);
        step();
        chk("fs_hold_req", 32'(imem_req), 32'd0);
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        push(32'h100);
        step();

        // PC wraps past the top of the address space.
        flush       = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        flush = 1'b0;
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC);
        step();
        chk("wrap_addr_zero", imem_addr, 32'h0);
        push(32'h0);
        step();

        // Asynchronous reset while parked in HOLD.
        ifid_write = 1'b0;
        step();
        chk("rsth_req_before", 32'(imem_req), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_hold");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        ifid_write = 1'b1;
        #1;
        chk("rsth_restart_req", 32'(imem_req), 32'd1);
        push(32'h0);
        step();

        // Asynchronous reset while draining an abandoned request.
        lat = 2;
        step();
        flush       = 1'b1;
        redirect_pc = 32'h200;
        step();
        flush = 1'b0;
        chk("rstd_drain_addr", imem_addr, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("rst_drain");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(32'h0);
        step();
        chk("rstd_restart_addr", imem_addr, 32'h0);
        step();
        step();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
